// File: rtl/pipeline_reg_ex_fwd.sv
// Execute-to-writeback stage register with stall/flush control, a short
// history of retired register writes, and two combinational forwarding
// lookup ports that search the stage output first, then the history.
module pipeline_reg_ex_fwd #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  write_enable_in,
  input  logic [REG_ADDR_W-1:0] rd_sel_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  output logic                  valid_out,
  output logic                  write_enable_out,
  output logic [REG_ADDR_W-1:0] rd_sel_out,
  output logic [DATA_W-1:0]     alu_result_out,
  input  logic [REG_ADDR_W-1:0] rs1_sel,
  input  logic [REG_ADDR_W-1:0] rs2_sel,
  output logic                  fwd1_hit,
  output logic [DATA_W-1:0]     fwd1_value,
  output logic                  fwd2_hit,
  output logic [DATA_W-1:0]     fwd2_value
);

  // ---- stage p0: execute result captured into the writeback stage ----
  logic                  r_valid_p0;
  logic                  r_we_p0;
  logic [REG_ADDR_W-1:0] r_rd_p0;
  logic [DATA_W-1:0]     r_res_p0;

  // ---- stage p1: retired-write history, index 0 is youngest ----
  logic                  r_hist_we_p1  [WB_DEPTH];
  logic [REG_ADDR_W-1:0] r_hist_rd_p1  [WB_DEPTH];
  logic [DATA_W-1:0]     r_hist_val_p1 [WB_DEPTH];

  logic w_we_qual;
  logic w_hist_adv;

  // A write is only real if the instruction is valid and targets a non-x0 register.
  assign w_we_qual  = write_enable_in & valid_in & (rd_sel_in != '0);
  // History moves whenever the stage is not held; a flush still retires the stage.
  assign w_hist_adv = ~stall | flush;

  // Stage register: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_p0 <= 1'b0;
      r_we_p0    <= 1'b0;
      r_rd_p0    <= '0;
      r_res_p0   <= '0;
    end else if (flush) begin
      r_valid_p0 <= 1'b0;
      r_we_p0    <= 1'b0;
      r_rd_p0    <= '0;
      r_res_p0   <= '0;
    end else if (!stall) begin
      r_valid_p0 <= valid_in;
      r_we_p0    <= w_we_qual;
      r_rd_p0    <= rd_sel_in;
      r_res_p0   <= alu_result_in;
    end
  end

  // History shift: the pre-edge stage contents enter slot 0, the oldest slot falls off.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WB_DEPTH; k++) begin
        r_hist_we_p1[k]  <= 1'b0;
        r_hist_rd_p1[k]  <= '0;
        r_hist_val_p1[k] <= '0;
      end
    end else if (w_hist_adv) begin
      r_hist_we_p1[0]  <= r_we_p0;
      r_hist_rd_p1[0]  <= r_rd_p0;
      r_hist_val_p1[0] <= r_res_p0;
      for (int k = 1; k < WB_DEPTH; k++) begin
        r_hist_we_p1[k]  <= r_hist_we_p1[k-1];
        r_hist_rd_p1[k]  <= r_hist_rd_p1[k-1];
        r_hist_val_p1[k] <= r_hist_val_p1[k-1];
      end
    end
  end

  assign valid_out        = r_valid_p0;
  assign write_enable_out = r_we_p0;
  assign rd_sel_out       = r_rd_p0;
  assign alu_result_out   = r_res_p0;

  // Forwarding lookup: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd1_hit   = 1'b0;
    fwd1_value = '0;
    fwd2_hit   = 1'b0;
    fwd2_value = '0;
    for (int k = WB_DEPTH - 1; k >= 0; k--) begin
      if (r_hist_we_p1[k] && (r_hist_rd_p1[k] == rs1_sel) && (rs1_sel != '0)) begin
        fwd1_hit   = 1'b1;
        fwd1_value = r_hist_val_p1[k];
      end
      if (r_hist_we_p1[k] && (r_hist_rd_p1[k] == rs2_sel) && (rs2_sel != '0)) begin
        fwd2_hit   = 1'b1;
        fwd2_value = r_hist_val_p1[k];
      end
    end
    if (r_we_p0 && (r_rd_p0 == rs1_sel) && (rs1_sel != '0)) begin
      fwd1_hit   = 1'b1;
      fwd1_value = r_res_p0;
    end
    if (r_we_p0 && (r_rd_p0 == rs2_sel) && (rs2_sel != '0)) begin
      fwd2_hit   = 1'b1;
      fwd2_value = r_res_p0;
    end
  end

endmodule

// File: tb/tb_pipeline_reg_ex_fwd.sv
// Directed bench for pipeline_reg_ex_fwd (DATA_W=32, REG_ADDR_W=5, WB_DEPTH=2).
module tb_pipeline_reg_ex_fwd;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic        write_enable_in;
  logic [4:0]  rd_sel_in;
  logic [31:0] alu_result_in;
  logic        valid_out;
  logic        write_enable_out;
  logic [4:0]  rd_sel_out;
  logic [31:0] alu_result_out;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic        fwd1_hit;
  logic [31:0] fwd1_value;
  logic        fwd2_hit;
  logic [31:0] fwd2_value;

  int errors = 0;
  int checks = 0;

  pipeline_reg_ex_fwd #(.DATA_W(32), .REG_ADDR_W(5), .WB_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(valid_in), .write_enable_in(write_enable_in),
    .rd_sel_in(rd_sel_in), .alu_result_in(alu_result_in),
    .valid_out(valid_out), .write_enable_out(write_enable_out),
    .rd_sel_out(rd_sel_out), .alu_result_out(alu_result_out),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .fwd1_hit(fwd1_hit), .fwd1_value(fwd1_value),
    .fwd2_hit(fwd2_hit), .fwd2_value(fwd2_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] res);
    valid_in        = v;
    write_enable_in = we;
    rd_sel_in       = rd;
    alu_result_in   = res;
  endtask

  task automatic fwd1(input string tag, input logic hit, input logic [31:0] val);
    chk({tag, "_hit1"}, {31'd0, fwd1_hit}, {31'd0, hit});
    chk({tag, "_val1"}, fwd1_value, val);
  endtask

  task automatic fwd2(input string tag, input logic hit, input logic [31:0] val);
    chk({tag, "_hit2"}, {31'd0, fwd2_hit}, {31'd0, hit});
    chk({tag, "_val2"}, fwd2_value, val);
  endtask

  task automatic stage(input string tag, input logic v, input logic we, input logic [4:0] rd, input logic [31:0] res);
    chk({tag, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    chk({tag, "_we"}, {31'd0, write_enable_out}, {31'd0, we});
    chk({tag, "_rd"}, {27'd0, rd_sel_out}, {27'd0, rd});
    chk({tag, "_res"}, alu_result_out, res);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rs1_sel = 5'd5; rs2_sel = 5'd0;
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD);
    step();
    step();
    stage("reset", 1'b0, 1'b0, 5'd0, 32'h0);
    fwd1("reset", 1'b0, 32'h0);

    // Load and one-cycle latency
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'h11);
    rs1_sel = 5'd3;
    step();
    stage("load", 1'b1, 1'b1, 5'd3, 32'h11);
    fwd1("load", 1'b1, 32'h11);

    // rd=0 never writes; x0 lookup always misses; rd=3 now in hist[0]
    drive(1'b1, 1'b1, 5'd0, 32'h22);
    step();
    rs1_sel = 5'd0; rs2_sel = 5'd3;
    #1;
    chk("x0_we", {31'd0, write_enable_out}, 32'd0);
    fwd1("x0", 1'b0, 32'h0);
    fwd2("h0_rd3", 1'b1, 32'h11);

    // invalid instruction never writes; rd=3 now in hist[1]
    drive(1'b0, 1'b1, 5'd4, 32'h44);
    step();
    rs1_sel = 5'd4;
    #1;
    stage("inval", 1'b0, 1'b0, 5'd4, 32'h44);
    fwd1("inval", 1'b0, 32'h0);
    fwd2("h1_rd3", 1'b1, 32'h11);

    // History priority
    drive(1'b1, 1'b1, 5'd7, 32'h1); step();
    drive(1'b1, 1'b1, 5'd7, 32'h2); step();
    drive(1'b1, 1'b1, 5'd9, 32'h3); step();
    rs1_sel = 5'd7; rs2_sel = 5'd9;
    #1;
    fwd1("prio_h0", 1'b1, 32'h2);
    fwd2("prio_stage", 1'b1, 32'h3);
    drive(1'b0, 1'b0, 5'd0, 32'h0); step();
    fwd1("prio_h1", 1'b1, 32'h2);
    fwd2("prio_h0_9", 1'b1, 32'h3);
    drive(1'b1, 1'b1, 5'd6, 32'h66); step();
    fwd1("drop7", 1'b0, 32'h0);
    fwd2("h1_9", 1'b1, 32'h3);

    // Stall for 3 cycles with changing inputs
    stall = 1'b1;
    rs1_sel = 5'd6;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd10 + 5'(i), 32'hB0 + 32'(i));
      step();
      stage("stall", 1'b1, 1'b1, 5'd6, 32'h66);
      fwd1("stall", 1'b1, 32'h66);
      fwd2("stall_h1", 1'b1, 32'h3);
    end
    stall = 1'b0;
    drive(1'b1, 1'b1, 5'd8, 32'hAA);
    step();
    stage("release", 1'b1, 1'b1, 5'd8, 32'hAA);
    fwd1("release_h0", 1'b1, 32'h66);
    fwd2("release_drop9", 1'b0, 32'h0);

    // Flush together with stall: stage cleared, old contents retire
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 1'b1, 5'd12, 32'hCC);
    rs1_sel = 5'd8; rs2_sel = 5'd6;
    step();
    stage("flush", 1'b0, 1'b0, 5'd0, 32'h0);
    fwd1("flush_h0", 1'b1, 32'hAA);
    fwd2("flush_h1", 1'b1, 32'h66);

    // Same rd in stage and history: stage wins
    flush = 1'b0; stall = 1'b0;
    drive(1'b1, 1'b1, 5'd8, 32'hBB);
    step();
    fwd1("stage_wins", 1'b1, 32'hBB);

    // Reset during a stall clears everything
    rst = 1'b1; stall = 1'b1;
    step();
    stage("rst_stall", 1'b0, 1'b0, 5'd0, 32'h0);
    fwd1("rst_stall", 1'b0, 32'h0);
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 1'b1, 5'd5, 32'h55);
    rs1_sel = 5'd5;
    step();
    stage("post_rst", 1'b1, 1'b1, 5'd5, 32'h55);
    fwd1("post_rst", 1'b1, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
